// File: rtl/pic_pkg.sv
// pic_pkg: shared ring helpers for the PIC core. Every vector is handled in
// a 32-bit container; only the low n bits take part in the ring, so the same
// helpers serve any request count from 2 to 32.
package pic_pkg;

  localparam int RING_MAX = 32;
  localparam logic [5:0] RANK_NONE = 6'd32;

  // Width of a level index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // (a + b) mod n for a, b < 32 and b < n.
  function automatic logic [5:0] ring_add(input logic [5:0] a, input logic [5:0] b, input int n);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 7'(n)) s = s - 7'(n);
    return s[5:0];
  endfunction

  // Rotate right around an n-bit ring: result[i] = v[(i + sh) mod n].
  function automatic logic [31:0] ring_rotr(input logic [31:0] v, input logic [5:0] sh, input int n);
    logic [31:0] r;
    logic [5:0]  src;
    r = '0;
    for (int i = 0; i < RING_MAX; i++) begin
      src = ring_add(6'(i), sh, n);
      if (i < n) r[i] = v[src[4:0]];
    end
    return r;
  endfunction

  // Rotate left around an n-bit ring: result[(i + sh) mod n] = v[i].
  function automatic logic [31:0] ring_rotl(input logic [31:0] v, input logic [5:0] sh, input int n);
    logic [31:0] r;
    logic [5:0]  dst;
    r = '0;
    for (int i = 0; i < RING_MAX; i++) begin
      dst = ring_add(6'(i), sh, n);
      if (i < n) r[dst[4:0]] = v[i];
    end
    return r;
  endfunction

  // Lowest set bit among the low n bits, RANK_NONE when none is set.
  function automatic logic [5:0] find_first(input logic [31:0] v, input int n);
    logic [5:0] r;
    r = RANK_NONE;
    for (int i = RING_MAX - 1; i >= 0; i--) begin
      if (i < n && v[i]) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_select.sv
// pic_priority_select: picks the highest-priority set bit of req, where the
// ring starts one past `lowest`. With `nested` set, an in-service bit of equal
// or higher priority than that bit suppresses the result.
module pic_priority_select
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W = idx_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] in_service,
  input  logic               nested,
  input  logic [IDX_W-1:0]   lowest,
  output logic               found,
  output logic [IDX_W-1:0]   level
);

  logic [5:0]  top_pos;
  logic [5:0]  req_rank;
  logic [5:0]  isr_rank;
  logic [5:0]  level_ext;
  logic [31:0] req_rot;
  logic [31:0] isr_rot;

  // Rotate so rank 0 is the highest priority, find first, apply nesting, unrotate.
  always_comb begin
    top_pos   = ring_add(6'(lowest), 6'd1, NUM_IRQ);
    req_rot   = ring_rotr(32'(req), top_pos, NUM_IRQ);
    isr_rot   = ring_rotr(32'(in_service), top_pos, NUM_IRQ);
    req_rank  = find_first(req_rot, NUM_IRQ);
    isr_rank  = find_first(isr_rot, NUM_IRQ);
    found     = (req_rank != RANK_NONE) && !(nested && (isr_rank <= req_rank));
    level_ext = ring_add(req_rank, top_pos, NUM_IRQ);
    level     = found ? IDX_W'(level_ext) : '0;
  end

endmodule

// File: rtl/pic_interrupt_controller_core.sv
// pic_interrupt_controller_core: IRR/ISR engine with fully-nested and rotating
// priority plus the acknowledge/EOI handshake.
// Optional feature macro: PIC_SPECIAL_MASK_MODE_EN adds the special_mask input;
// without it the controller is always fully nested.
module pic_interrupt_controller_core
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  localparam int IDX_W = idx_width(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_triggered,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               auto_rotate,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [IDX_W-1:0]   eoi_level,
  input  logic               set_prio_valid,
  input  logic [IDX_W-1:0]   set_prio_level,
  input  logic               ack_valid,
`ifdef PIC_SPECIAL_MASK_MODE_EN
  input  logic               special_mask,
`endif
  output logic               int_req,
  output logic               ack_vector_valid,
  output logic [IDX_W-1:0]   ack_vector,
  output logic               ack_spurious,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [IDX_W-1:0]   lowest_prio
);

  localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

  logic               smm;
  logic [NUM_IRQ-1:0] irq_prev_reg, irr_reg, isr_reg;
  logic [NUM_IRQ-1:0] irr_next, isr_next;
  logic [IDX_W-1:0]   lowest_reg, lowest_next;
  logic               int_req_reg, vec_valid_reg, spurious_reg;
  logic [IDX_W-1:0]   vec_reg;

  logic [NUM_IRQ-1:0] req_vec;
  logic               cand_found, isr_found;
  logic [IDX_W-1:0]   cand_level, isr_top;
  logic               rotate;
  logic [NUM_IRQ-1:0] ack_set, eoi_clear;

`ifdef PIC_SPECIAL_MASK_MODE_EN
  assign smm = special_mask;
`else
  assign smm = 1'b0;
`endif

  // In special mask mode a level's own in-service bit removes it from contention.
  assign req_vec = irr_reg & ~imr & ~(isr_reg & {NUM_IRQ{smm}});

  pic_priority_select #(.NUM_IRQ(NUM_IRQ)) u_req_sel (
    .req        (req_vec),
    .in_service (isr_reg),
    .nested     (~smm),
    .lowest     (lowest_reg),
    .found      (cand_found),
    .level      (cand_level)
  );

  pic_priority_select #(.NUM_IRQ(NUM_IRQ)) u_isr_sel (
    .req        (isr_reg),
    .in_service ('0),
    .nested     (1'b0),
    .lowest     (lowest_reg),
    .found      (isr_found),
    .level      (isr_top)
  );

  // Next IRR/ISR/priority: ack resolves on pre-EOI ISR and its set beats an EOI clear.
  always_comb begin
    ack_set   = (ack_valid && cand_found) ? (ONE << cand_level) : '0;
    rotate    = eoi_valid && !eoi_specific && isr_found && auto_rotate;
    eoi_clear = '0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        if (32'(eoi_level) < 32'(NUM_IRQ)) eoi_clear = ONE << eoi_level;
      end else if (isr_found) begin
        eoi_clear = ONE << isr_top;
      end
    end
    isr_next = (isr_reg & ~eoi_clear) | ack_set;

    if (level_triggered) irr_next = irq_in;
    else                 irr_next = (irr_reg & ~ack_set) | (irq_in & ~irq_prev_reg);

    lowest_next = lowest_reg;
    if (rotate)
      lowest_next = isr_top;
    else if (set_prio_valid && (32'(set_prio_level) < 32'(NUM_IRQ)))
      lowest_next = set_prio_level;
  end

  // Register all state and the CPU-facing outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_prev_reg  <= '0;
      irr_reg       <= '0;
      isr_reg       <= '0;
      lowest_reg    <= IDX_W'(NUM_IRQ - 1);
      int_req_reg   <= 1'b0;
      vec_valid_reg <= 1'b0;
      spurious_reg  <= 1'b0;
      vec_reg       <= '0;
    end else begin
      irq_prev_reg  <= irq_in;
      irr_reg       <= irr_next;
      isr_reg       <= isr_next;
      lowest_reg    <= lowest_next;
      int_req_reg   <= cand_found;
      vec_valid_reg <= ack_valid;
      if (ack_valid) begin
        vec_reg      <= cand_found ? cand_level : IDX_W'(NUM_IRQ - 1);
        spurious_reg <= !cand_found;
      end
    end
  end

  assign int_req          = int_req_reg;
  assign ack_vector_valid = vec_valid_reg;
  assign ack_vector       = vec_reg;
  assign ack_spurious     = spurious_reg;
  assign irr              = irr_reg;
  assign isr              = isr_reg;
  assign lowest_prio      = lowest_reg;

endmodule

// File: tb/tb_pic_interrupt_controller_core.sv
// Bench for pic_interrupt_controller_core: an 8-line and a 5-line instance
// share stimulus; a ring-walking reference model predicts both every cycle.
module tb_pic_interrupt_controller_core;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] irq_in, imr;
  logic       level_triggered, auto_rotate, eoi_valid, eoi_specific;
  logic       set_prio_valid, ack_valid;
  logic [2:0] eoi_level, set_prio_level;
`ifdef PIC_SPECIAL_MASK_MODE_EN
  logic       special_mask;
`endif

  logic       int_req_a, vv_a, sp_a;
  logic [2:0] vec_a, low_a;
  logic [7:0] irr_a, isr_a;
  logic       int_req_b, vv_b, sp_b;
  logic [2:0] vec_b, low_b;
  logic [4:0] irr_b, isr_b, irq_b, imr_b;

  int checks = 0;
  int errors = 0;

  assign irq_b = irq_in[4:0];
  assign imr_b = imr[4:0];

  always #5 clock = ~clock;

  pic_interrupt_controller_core #(.NUM_IRQ(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .level_triggered(level_triggered),
    .imr(imr), .auto_rotate(auto_rotate), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .set_prio_valid(set_prio_valid), .set_prio_level(set_prio_level),
    .ack_valid(ack_valid),
`ifdef PIC_SPECIAL_MASK_MODE_EN
    .special_mask(special_mask),
`endif
    .int_req(int_req_a), .ack_vector_valid(vv_a), .ack_vector(vec_a), .ack_spurious(sp_a),
    .irr(irr_a), .isr(isr_a), .lowest_prio(low_a)
  );

  pic_interrupt_controller_core #(.NUM_IRQ(5)) dut_b (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_b), .level_triggered(level_triggered),
    .imr(imr_b), .auto_rotate(auto_rotate), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .set_prio_valid(set_prio_valid), .set_prio_level(set_prio_level),
    .ack_valid(ack_valid),
`ifdef PIC_SPECIAL_MASK_MODE_EN
    .special_mask(special_mask),
`endif
    .int_req(int_req_b), .ack_vector_valid(vv_b), .ack_vector(vec_b), .ack_spurious(sp_b),
    .irr(irr_b), .isr(isr_b), .lowest_prio(low_b)
  );

  // Reference state, index 0 = 8-line instance, 1 = 5-line instance.
  logic [31:0] m_irr [2];
  logic [31:0] m_isr [2];
  logic [31:0] m_prev [2];
  int          m_low [2];
  int          m_vec [2];
  logic        m_int [2];
  logic        m_vv [2];
  logic        m_sp [2];

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  // Walk from the highest priority downward; an in-service level ends the walk when nested.
  function automatic int pick(input int n, input int low, input logic [31:0] req,
                              input logic [31:0] blk, input logic nested);
    int l;
    for (int k = 0; k < n; k++) begin
      l = (low + 1 + k) % n;
      if (nested && blk[l]) return -1;
      if (req[l]) return l;
    end
    return -1;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int n, w, h, nlow;
    logic [31:0] mask, irq, req, nirr, nisr;
    logic smm, rotated;
`ifdef PIC_SPECIAL_MASK_MODE_EN
    smm = special_mask;
`else
    smm = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      n    = n_of(d);
      mask = (32'd1 << n) - 32'd1;
      irq  = 32'(irq_in) & mask;
      req  = m_irr[d] & ~32'(imr) & mask;
      if (smm) req = req & ~m_isr[d];
      w = pick(n, m_low[d], req, m_isr[d], !smm);
      h = pick(n, m_low[d], m_isr[d], 32'd0, 1'b0);
      if (!reset_n) begin
        m_irr[d] = 0; m_isr[d] = 0; m_prev[d] = 0; m_low[d] = n - 1;
        m_vec[d] = 0; m_int[d] = 0; m_vv[d] = 0; m_sp[d] = 0;
      end else begin
        nirr = level_triggered ? irq : m_irr[d];
        if (!level_triggered) begin
          if (ack_valid && w >= 0) nirr[w] = 1'b0;
          nirr = nirr | (irq & ~m_prev[d]);
        end
        nisr = m_isr[d];
        nlow = m_low[d];
        rotated = 1'b0;
        if (eoi_valid) begin
          if (eoi_specific) begin
            if (int'(eoi_level) < n) nisr[eoi_level] = 1'b0;
          end else if (h >= 0) begin
            nisr[h] = 1'b0;
            if (auto_rotate) begin nlow = h; rotated = 1'b1; end
          end
        end
        if (set_prio_valid && !rotated && int'(set_prio_level) < n) nlow = int'(set_prio_level);
        m_vv[d] = ack_valid;
        if (ack_valid) begin
          if (w >= 0) begin nisr[w] = 1'b1; m_vec[d] = w; m_sp[d] = 1'b0; end
          else begin m_vec[d] = n - 1; m_sp[d] = 1'b1; end
        end
        m_int[d]  = (w >= 0);
        m_prev[d] = irq;
        m_irr[d]  = nirr;
        m_isr[d]  = nisr;
        m_low[d]  = nlow;
      end
    end
  endtask

  task automatic check_all();
    check_value("irr_a", 32'(irr_a), m_irr[0]);
    check_value("isr_a", 32'(isr_a), m_isr[0]);
    check_value("lowest_a", 32'(low_a), 32'(m_low[0]));
    check_value("int_req_a", 32'(int_req_a), 32'(m_int[0]));
    check_value("vec_valid_a", 32'(vv_a), 32'(m_vv[0]));
    if (m_vv[0]) begin
      check_value("vector_a", 32'(vec_a), 32'(m_vec[0]));
      check_value("spurious_a", 32'(sp_a), 32'(m_sp[0]));
      $display("ack n=8 vector %0d spurious %0d", vec_a, sp_a);
    end
    check_value("irr_b", 32'(irr_b), m_irr[1]);
    check_value("isr_b", 32'(isr_b), m_isr[1]);
    check_value("lowest_b", 32'(low_b), 32'(m_low[1]));
    check_value("int_req_b", 32'(int_req_b), 32'(m_int[1]));
    check_value("vec_valid_b", 32'(vv_b), 32'(m_vv[1]));
    if (m_vv[1]) begin
      check_value("vector_b", 32'(vec_b), 32'(m_vec[1]));
      check_value("spurious_b", 32'(sp_b), 32'(m_sp[1]));
      $display("ack n=5 vector %0d spurious %0d", vec_b, sp_b);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_all();
    ack_valid      = 1'b0;
    eoi_valid      = 1'b0;
    set_prio_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    irq_in  = 8'h00;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0; irq_in = 8'h00; imr = 8'h00; level_triggered = 1'b0;
    auto_rotate = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    set_prio_valid = 1'b0; set_prio_level = 3'd0; ack_valid = 1'b0;
`ifdef PIC_SPECIAL_MASK_MODE_EN
    special_mask = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      m_irr[d] = 0; m_isr[d] = 0; m_prev[d] = 0; m_low[d] = n_of(d) - 1;
      m_vec[d] = 0; m_int[d] = 0; m_vv[d] = 0; m_sp[d] = 0;
    end

    // Reset values.
    step();
    step();
    check_value("rst_lowest_a", 32'(low_a), 32'd7);
    check_value("rst_lowest_b", 32'(low_b), 32'd4);
    check_value("rst_vector_a", 32'(vec_a), 32'd0);
    check_value("rst_int_req_a", 32'(int_req_a), 32'd0);
    reset_n = 1'b1;
    step();

    // irq 3 and 5 rise together: IRR next cycle, int_req the one after.
    irq_in = 8'h28; step();
    check_value("edge_irr", 32'(irr_a), 32'h28);
    check_value("edge_int_early", 32'(int_req_a), 32'd0);
    step();
    check_value("edge_int_req", 32'(int_req_a), 32'd1);
    ack_valid = 1'b1; step();
    check_value("ack3_vector", 32'(vec_a), 32'd3);
    check_value("ack3_isr", 32'(isr_a), 32'h08);
    check_value("ack3_irr", 32'(irr_a), 32'h20);
    step();
    check_value("nested_block", 32'(int_req_a), 32'd0);

    // irq 1 preempts level 3; irq 6 waits for both EOIs.
    irq_in = 8'h2A; step(); step();
    check_value("preempt_int", 32'(int_req_a), 32'd1);
    ack_valid = 1'b1; step();
    check_value("ack1_vector", 32'(vec_a), 32'd1);
    check_value("ack1_isr", 32'(isr_a), 32'h0A);
    irq_in = 8'h6A; step(); step();
    check_value("blocked6_int", 32'(int_req_a), 32'd0);
    eoi_valid = 1'b1; eoi_specific = 1'b0; step();
    check_value("eoi1_isr", 32'(isr_a), 32'h08);
    step();
    check_value("still_blocked", 32'(int_req_a), 32'd0);
    eoi_valid = 1'b1; step();
    step();
    check_value("unblocked_int", 32'(int_req_a), 32'd1);
    ack_valid = 1'b1; step();
    check_value("ack5_vector", 32'(vec_a), 32'd5);
    check_value("spur_b_vector", 32'(vec_b), 32'd4);
    check_value("spur_b_flag", 32'(sp_b), 32'd1);

    // Auto-rotate on non-specific EOI, then scan from level 3.
    do_reset();
    irq_in = 8'h04; step(); step();
    ack_valid = 1'b1; step();
    auto_rotate = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b0; step();
    check_value("rot_isr", 32'(isr_a), 32'h00);
    check_value("rot_lowest", 32'(low_a), 32'd2);
    irq_in = 8'h00; step();
    irq_in = 8'h14; step(); step();
    ack_valid = 1'b1; step();
    check_value("rot_ack4", 32'(vec_a), 32'd4);
    auto_rotate = 1'b0;
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4; step();
    ack_valid = 1'b1; step();
    check_value("rot_ack2", 32'(vec_a), 32'd2);

    // Ack and specific EOI of the same level in one cycle: set wins.
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2; step();
    irq_in = 8'h54; step();
    ack_valid = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd6; step();
    check_value("ack_eoi_same", 32'(isr_a), 32'h40);

    // Out-of-range priority level ignored by the 5-line instance.
    set_prio_valid = 1'b1; set_prio_level = 3'd6; step();
    check_value("setprio_a", 32'(low_a), 32'd6);
    check_value("setprio_b_ignored", 32'(low_b), 32'd2);

    // Reset during an acknowledge discards the vector pulse.
    ack_valid = 1'b1; reset_n = 1'b0; step();
    check_value("reset_kills_pulse", 32'(vv_a), 32'd0);
    reset_n = 1'b1; step();

`ifdef PIC_SPECIAL_MASK_MODE_EN
    // Special mask: an in-service level 0 no longer blocks level 4.
    do_reset();
    special_mask = 1'b1;
    irq_in = 8'h01; step(); step();
    ack_valid = 1'b1; step();
    irq_in = 8'h11; step(); step();
    ack_valid = 1'b1; step();
    check_value("smm_vector", 32'(vec_a), 32'd4);
    special_mask = 1'b0;
`endif

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      irq_in = irq_in ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 199) == 0) imr = 8'($urandom & $urandom);
      if ($urandom_range(0, 299) == 0) level_triggered = ~level_triggered;
      if ($urandom_range(0, 49) == 0) auto_rotate = 1'($urandom);
`ifdef PIC_SPECIAL_MASK_MODE_EN
      if ($urandom_range(0, 149) == 0) special_mask = 1'($urandom);
`endif
      ack_valid      = ($urandom_range(0, 5) == 0);
      eoi_valid      = ($urandom_range(0, 4) == 0);
      eoi_specific   = 1'($urandom);
      eoi_level      = 3'($urandom_range(0, 7));
      set_prio_valid = ($urandom_range(0, 9) == 0);
      set_prio_level = 3'($urandom_range(0, 7));
      reset_n        = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
